// File: rtl/prog_loader.sv
// prog_loader: receives a big-endian byte stream over valid/ready, assembles
// 16-bit instruction words, writes them to instruction memory from address 0,
// and releases the CPU (cpu_run) once the halt word 16'hFFFF has been stored.
module prog_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [15:0]       HALT_WORD = 16'hFFFF;

    state_t              state_r;
    state_t              state_s;
    logic [15:0]         word_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   count_r;
    // Low for the first edge after reset release so start is only honoured
    // from the second edge onwards.
    logic                armed_r;

    logic                ready_s;
    logic                we_s;
    logic                run_s;
    logic                busy_s;
    logic                done_s;
    logic                ovf_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE, DONE and ERR.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && armed_r) begin
                    state_s = ST_HI;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (byte_valid) begin
                    state_s = ST_LO;
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_LO: begin
                if (byte_valid) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_WRITE: begin
                // Halt takes priority so a halt in the last slot is a success.
                if (word_r == HALT_WORD) begin
                    state_s = ST_DONE;
                end else if (addr_r == LAST_ADDR) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_s = ST_HI;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state only (no input-to-output path).
    always_comb begin
        ready_s = 1'b0;
        we_s    = 1'b0;
        run_s   = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ovf_s   = 1'b0;
        case (state_r)
            ST_HI, ST_LO: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_WRITE: begin
                we_s   = 1'b1;
                busy_s = 1'b1;
            end
            ST_DONE: begin
                run_s  = 1'b1;
                done_s = 1'b1;
            end
            ST_ERR: begin
                ovf_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Datapath: word assembly, write address and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r  <= 16'h0000;
            addr_r  <= '0;
            count_r <= '0;
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (state_s == ST_HI) begin
                        addr_r  <= '0;
                        count_r <= '0;
                    end else begin
                        addr_r  <= addr_r;
                        count_r <= count_r;
                    end
                end
                ST_HI: begin
                    if (byte_valid) begin
                        word_r[15:8] <= byte_data;
                    end else begin
                        word_r <= word_r;
                    end
                end
                ST_LO: begin
                    if (byte_valid) begin
                        word_r[7:0] <= byte_data;
                    end else begin
                        word_r <= word_r;
                    end
                end
                ST_WRITE: begin
                    count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (state_s == ST_HI) begin
                        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                default: begin
                    word_r <= word_r;
                end
            endcase
        end
    end

    assign byte_ready = ready_s;
    assign imem_we    = we_s;
    assign imem_addr  = addr_r;
    assign imem_wdata = word_r;
    assign cpu_run    = run_s;
    assign busy       = busy_s;
    assign done       = done_s;
    assign overflow   = ovf_s;
    assign word_count = count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: a 256-word instance (big) and a 4-word
// instance (small) share clock, reset and the byte stream, with separate starts.
`timescale 1ns/1ps
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_start, s_start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        b_ready, b_we, b_run, b_busy, b_done, b_ovf;
    logic [15:0] b_addr, b_wdata, b_wc;
    logic        s_ready, s_we, s_run, s_busy, s_done, s_ovf;
    logic [15:0] s_addr, s_wdata, s_wc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wr_big[$];
    logic [31:0] wr_small[$];

    prog_loader #(.MAX_WORDS(256), .ADDR_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .cpu_run(b_run), .busy(b_busy),
        .done(b_done), .overflow(b_ovf), .word_count(b_wc)
    );

    prog_loader #(.MAX_WORDS(4), .ADDR_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .cpu_run(s_run), .busy(s_busy),
        .done(s_done), .overflow(s_ovf), .word_count(s_wc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every memory write; byte_ready must be low while writing.
    always @(negedge clk) begin
        if (b_we === 1'b1) begin
            wr_big.push_back({b_addr, b_wdata});
            check_eq("big_ready_low_in_write", b_ready, 1'b0);
        end
        if (s_we === 1'b1) begin
            wr_small.push_back({s_addr, s_wdata});
            check_eq("small_ready_low_in_write", s_ready, 1'b0);
        end
    end

    task automatic check_wr(input string tag, input logic sel, input int idx,
                            input logic [15:0] a, input logic [15:0] d);
        logic [31:0] obs;
        if (sel) obs = (idx < wr_small.size()) ? wr_small[idx] : 32'hxxxxxxxx;
        else     obs = (idx < wr_big.size())   ? wr_big[idx]   : 32'hxxxxxxxx;
        check_eq(tag, {32'h0, obs}, {32'h0, a, d});
    endtask

    task automatic pulse_start(input logic sel);
        @(negedge clk);
        if (sel) s_start = 1'b1; else b_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the consuming edge.
    task automatic send_byte(input logic sel, input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if ((sel ? s_ready : b_ready) === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic sel, input logic [15:0] w, input int gap);
        send_byte(sel, w[15:8], gap);
        send_byte(sel, w[7:0], gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; b_start = 1'b0; s_start = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_big_outs", {b_ready, b_we, b_addr, b_wdata, b_run, b_busy, b_done, b_ovf, b_wc}, 64'h0);
        check_eq("rst_small_outs", {s_ready, s_we, s_addr, s_wdata, s_run, s_busy, s_done, s_ovf, s_wc}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load 1234, ABCD, FFFF with latency checks
        pulse_start(1'b0);
        check_eq("start_ready_latency", b_ready, 1'b1);
        check_eq("start_busy", b_busy, 1'b1);
        send_byte(1'b0, 8'h12, 0);
        send_byte(1'b0, 8'h34, 0);
        check_eq("lo_to_we_latency", b_we, 1'b1);
        send_word(1'b0, 16'hABCD, 0);
        send_word(1'b0, 16'hFFFF, 0);
        check_eq("halt_we", b_we, 1'b1);
        check_eq("halt_run_not_yet", b_run, 1'b0);
        @(negedge clk);
        check_eq("basic_run", b_run, 1'b1);
        check_eq("basic_done", b_done, 1'b1);
        check_eq("basic_wc", b_wc, 16'd3);
        check_eq("basic_busy", b_busy, 1'b0);
        check_eq("basic_nwr", wr_big.size(), 3);
        check_wr("basic_w0", 1'b0, 0, 16'd0, 16'h1234);
        check_wr("basic_w1", 1'b0, 1, 16'd1, 16'hABCD);
        check_wr("basic_w2", 1'b0, 2, 16'd2, 16'hFFFF);

        // Backpressure: 5 idle cycles before every byte
        wr_big.delete();
        pulse_start(1'b0);
        check_eq("restart_run_falls", b_run, 1'b0);
        check_eq("restart_done_falls", b_done, 1'b0);
        send_word(1'b0, 16'h1234, 5);
        send_word(1'b0, 16'hABCD, 5);
        send_word(1'b0, 16'hFFFF, 5);
        repeat (2) @(negedge clk);
        check_eq("bp_nwr", wr_big.size(), 3);
        check_wr("bp_w0", 1'b0, 0, 16'd0, 16'h1234);
        check_wr("bp_w1", 1'b0, 1, 16'd1, 16'hABCD);
        check_wr("bp_w2", 1'b0, 2, 16'd2, 16'hFFFF);
        check_eq("bp_wc", b_wc, 16'd3);
        check_eq("bp_done", b_done, 1'b1);

        // start pulsed while in LO is ignored; new load restarts at address 0
        wr_big.delete();
        pulse_start(1'b0);
        send_byte(1'b0, 8'h00, 0);
        pulse_start(1'b0);
        check_eq("lo_start_ignored_ready", b_ready, 1'b1);
        send_byte(1'b0, 8'hAA, 0);
        send_word(1'b0, 16'hFFFF, 0);
        repeat (2) @(negedge clk);
        check_eq("reload_nwr", wr_big.size(), 2);
        check_wr("reload_w0", 1'b0, 0, 16'd0, 16'h00AA);
        check_wr("reload_w1", 1'b0, 1, 16'd1, 16'hFFFF);
        check_eq("reload_wc", b_wc, 16'd2);
        check_eq("reload_done", b_done, 1'b1);

        // Overflow on the 4-word instance
        wr_small.delete();
        pulse_start(1'b1);
        send_word(1'b1, 16'h0001, 0);
        send_word(1'b1, 16'h0002, 0);
        send_word(1'b1, 16'h0003, 0);
        send_word(1'b1, 16'h0004, 0);
        repeat (2) @(negedge clk);
        check_eq("ovf_flag", s_ovf, 1'b1);
        check_eq("ovf_run", s_run, 1'b0);
        check_eq("ovf_done", s_done, 1'b0);
        check_eq("ovf_busy", s_busy, 1'b0);
        check_eq("ovf_wc", s_wc, 16'd4);
        check_eq("ovf_nwr", wr_small.size(), 4);
        check_wr("ovf_w0", 1'b1, 0, 16'd0, 16'h0001);
        check_wr("ovf_w3", 1'b1, 3, 16'd3, 16'h0004);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        check_eq("ovf_no_accept", s_ready, 1'b0);
        byte_valid = 1'b0;
        check_eq("ovf_wc_hold", s_wc, 16'd4);
        check_eq("ovf_nwr_hold", wr_small.size(), 4);
        check_eq("big_ignores_stream", b_wc, 16'd2);

        // Halt word in the last slot is a success
        wr_small.delete();
        pulse_start(1'b1);
        check_eq("restart_ovf_clear", s_ovf, 1'b0);
        send_word(1'b1, 16'h0001, 0);
        send_word(1'b1, 16'h0002, 0);
        send_word(1'b1, 16'h0003, 0);
        send_word(1'b1, 16'hFFFF, 0);
        repeat (2) @(negedge clk);
        check_eq("last_done", s_done, 1'b1);
        check_eq("last_ovf", s_ovf, 1'b0);
        check_eq("last_run", s_run, 1'b1);
        check_eq("last_wc", s_wc, 16'd4);
        check_wr("last_w3", 1'b1, 3, 16'd3, 16'hFFFF);

        // Reset in the middle of a load
        wr_big.delete();
        pulse_start(1'b0);
        send_byte(1'b0, 8'h12, 0);
        send_byte(1'b0, 8'h34, 0);
        send_byte(1'b0, 8'hAB, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_big_outs", {b_ready, b_we, b_addr, b_wdata, b_run, b_busy, b_done, b_ovf, b_wc}, 64'h0);
        check_eq("midrst_small_outs", {s_ready, s_we, s_addr, s_wdata, s_run, s_busy, s_done, s_ovf, s_wc}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_big.delete();
        repeat (2) @(negedge clk);
        pulse_start(1'b0);
        send_word(1'b0, 16'h0011, 0);
        send_word(1'b0, 16'hFFFF, 0);
        repeat (2) @(negedge clk);
        check_eq("postrst_nwr", wr_big.size(), 2);
        check_wr("postrst_w0", 1'b0, 0, 16'd0, 16'h0011);
        check_wr("postrst_w1", 1'b0, 1, 16'd1, 16'hFFFF);
        check_eq("postrst_wc", b_wc, 16'd2);
        check_eq("postrst_done", b_done, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
